// File: rtl/rgb_frame_reader.sv
// Streams one RGB frame from a synchronous pixel memory into the write side of
// the Sobel RGB input FIFO, absorbing the memory's 1-cycle read latency.
module rgb_frame_reader #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540,
    parameter int RGB_DWIDTH = 24,
    parameter int ADDR_WIDTH = 19,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [RGB_DWIDTH-1:0] mem_dout,
    output logic                  fifo_wr_en,
    output logic [RGB_DWIDTH-1:0] fifo_din,
    input  logic                  fifo_full
);

    localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      idx;
    logic                  inflight;
    logic [1:0]            occ;
    logic                  rd_ptr, wr_ptr;
    logic [RGB_DWIDTH-1:0] hold_buf [2];
    logic [2:0]            credits;

    // A read may only be issued if its data will find a free slot when it
    // lands: entries held plus the one in flight, minus what leaves this cycle.
    assign credits = 3'(occ) + 3'(inflight) - 3'(fifo_wr_en);

    assign mem_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
    assign fifo_din = hold_buf[rd_ptr];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        fifo_wr_en = (occ != 2'd0) && !fifo_full;

        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_READ;
            end
            S_READ: begin
                busy      = 1'b1;
                mem_rd_en = (idx < TOTAL_C) && (credits < 3'd2);
                if (mem_rd_en && (idx == LAST_IDX)) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Leave as soon as the buffer empties this cycle, so done lands
                // one cycle after the final FIFO write.
                if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && fifo_wr_en)))
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= mem_rd_en;
            if ((state == S_IDLE) && start)
                idx <= '0;
            else if (mem_rd_en)
                idx <= idx + CNT_W'(1);
        end
    end

    // NOTE: the two holding entries are reset as well, because the head entry
    // drives fifo_din directly and must read as zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_buf[0] <= '0;
            hold_buf[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            if (inflight) begin
                hold_buf[wr_ptr] <= mem_dout;
                wr_ptr           <= ~wr_ptr;
            end
            if (fifo_wr_en)
                rd_ptr <= ~rd_ptr;
            occ <= occ + 2'(inflight) - 2'(fifo_wr_en);
        end
    end

endmodule

// File: tb/tb_rgb_frame_reader.sv
// Bench for rgb_frame_reader: a 4x3 frame (base 16) and a 16x8 frame (base 32),
// memory word = addr*3, checked against expected write order and latencies.
module tb_rgb_frame_reader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic fifo_full = 1'b0;
    logic sel = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    logic        start_a, busy_a, done_a, rd_a, wr_a, full_a;
    logic [7:0]  addr_a;
    logic [23:0] dout_a = '0, din_a;
    logic        start_b, busy_b, done_b, rd_b, wr_b, full_b;
    logic [7:0]  addr_b;
    logic [23:0] dout_b = '0, din_b;

    assign start_a = start && !sel;
    assign full_a  = fifo_full && !sel;
    assign start_b = start && sel;
    assign full_b  = fifo_full && sel;

    rgb_frame_reader #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .RGB_DWIDTH(24),
                       .ADDR_WIDTH(8), .BASE_ADDR(16)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_dout(dout_a),
        .fifo_wr_en(wr_a), .fifo_din(din_a), .fifo_full(full_a));

    rgb_frame_reader #(.IMG_WIDTH(16), .IMG_HEIGHT(8), .RGB_DWIDTH(24),
                       .ADDR_WIDTH(8), .BASE_ADDR(32)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_dout(dout_b),
        .fifo_wr_en(wr_b), .fifo_din(din_b), .fifo_full(full_b));

    // Synchronous pixel memories: word = address * 3, one cycle of latency.
    always @(posedge clock) begin
        if (rd_a) dout_a <= 24'(int'(addr_a) * 3);
        if (rd_b) dout_b <= 24'(int'(addr_b) * 3);
    end

    logic        m_rd, m_wr, m_done, m_busy;
    logic [7:0]  m_addr;
    logic [23:0] m_din;
    assign m_rd   = sel ? rd_b   : rd_a;
    assign m_wr   = sel ? wr_b   : wr_a;
    assign m_done = sel ? done_b : done_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_addr = sel ? addr_b : addr_a;
    assign m_din  = sel ? din_b  : din_a;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Per-cycle record of the last frame run.
    bit rec_rd [1024];
    bit rec_wr [1024];
    bit rec_done [1024];
    bit rec_busy [1024];
    int rec_addr [1024];
    int rec_din [1024];

    // Results of the last frame run.
    int r_writes, r_last_wr, r_done_c, r_done_cnt, r_max_out;
    int r_order_bad, r_addr_bad, r_stall_wr, r_next_rd, r_next_addr;
    bit r_timeout;

    // Runs one frame from the selected DUT. Cycle 0 is the cycle start is first
    // high. mode: 0 no backpressure, 1 full in cycles 4-9, 2 random 50% full.
    // The model expects the k-th read at base+k and the k-th write to carry
    // (base+k)*3, never more than 2 reads ahead of the writes.
    task automatic run_frame(input bit s, input int total, input int base, input int mode,
                             input bit hold, input int abort_at);
        int  reads;
        bit  aborted;
        reads = 0;
        aborted = 1'b0;
        r_writes = 0; r_last_wr = -1; r_done_c = -1; r_done_cnt = 0; r_max_out = 0;
        r_order_bad = 0; r_addr_bad = 0; r_stall_wr = 0; r_next_rd = -1; r_next_addr = -1;
        sel = s;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            start = (c == 0) || hold;
            case (mode)
                1:       fifo_full = (c >= 4) && (c <= 9);
                2:       fifo_full = ($urandom_range(0, 1) == 1);
                default: fifo_full = 1'b0;
            endcase
            #1;
            rec_rd[c] = m_rd; rec_wr[c] = m_wr; rec_done[c] = m_done; rec_busy[c] = m_busy;
            rec_addr[c] = int'(m_addr); rec_din[c] = int'(m_din);
            if (m_rd) begin
                if (r_done_c < 0) begin
                    if (int'(m_addr) != base + reads) r_addr_bad++;
                    reads++;
                end else if (r_next_rd < 0) begin
                    r_next_rd = c;
                    r_next_addr = int'(m_addr);
                end
            end
            if (m_wr) begin
                if (int'(m_din) != (base + r_writes) * 3) r_order_bad++;
                if (fifo_full) r_stall_wr++;
                r_writes++;
                r_last_wr = c;
            end
            if (reads - r_writes > r_max_out) r_max_out = reads - r_writes;
            if (m_done) begin
                r_done_cnt++;
                if (r_done_c < 0) r_done_c = c;
            end
            if ((abort_at > 0) && (r_writes == abort_at)) begin
                aborted = 1'b1;
                break;
            end
            if (hold && (r_next_rd >= 0)) break;
            if (!hold && (r_done_c >= 0) && (c >= r_done_c + 3)) break;
        end
        r_timeout = !aborted && ((r_done_c < 0) || (hold && (r_next_rd < 0)));
        start = 1'b0;
        fifo_full = 1'b0;
        if (r_writes > total) r_order_bad++;
    endtask

    typedef struct {
        bit rd;
        int addr;
        bit wr;
        int din;
        bit done;
        bit busy;
    } vec_t;

    vec_t vecs [18];
    int   stalled;
    bit   got_done;

    initial begin
        // Expected free-running timeline of the 4x3 frame at base 16.
        for (int c = 0; c < 18; c++) begin
            vecs[c].rd   = (c >= 1) && (c <= 12);
            vecs[c].addr = 16 + c - 1;
            vecs[c].wr   = (c >= 3) && (c <= 14);
            vecs[c].din  = (16 + c - 3) * 3;
            vecs[c].done = (c == 15);
            vecs[c].busy = (c >= 1) && (c <= 14);
        end

        // Reset held with inputs toggling.
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            start = (c % 2 == 0);
            fifo_full = (c % 2 == 1);
            #1;
            check($sformatf("rst c%0d rd", c), 64'(rd_a), 64'(0));
            check($sformatf("rst c%0d wr", c), 64'(wr_a), 64'(0));
            check($sformatf("rst c%0d done", c), 64'(done_a), 64'(0));
            check($sformatf("rst c%0d busy", c), 64'(busy_a), 64'(0));
            check($sformatf("rst c%0d addr", c), 64'(addr_a), 64'(16));
            check($sformatf("rst c%0d din", c), 64'(din_a), 64'(0));
        end
        @(negedge clock);
        start = 1'b0;
        fifo_full = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1;
            check($sformatf("idle c%0d strobes", c), 64'({rd_a, wr_a, done_a, busy_a}), 64'(0));
        end

        // Free-running frame against the timeline table.
        run_frame(1'b0, 12, 16, 0, 1'b0, 0);
        for (int c = 0; c < 18; c++) begin
            check($sformatf("free c%0d rd", c), 64'(rec_rd[c]), 64'(vecs[c].rd));
            check($sformatf("free c%0d wr", c), 64'(rec_wr[c]), 64'(vecs[c].wr));
            check($sformatf("free c%0d done", c), 64'(rec_done[c]), 64'(vecs[c].done));
            check($sformatf("free c%0d busy", c), 64'(rec_busy[c]), 64'(vecs[c].busy));
            if (vecs[c].rd) check($sformatf("free c%0d addr", c), 64'(rec_addr[c]), 64'(vecs[c].addr));
            if (vecs[c].wr) check($sformatf("free c%0d din", c), 64'(rec_din[c]), 64'(vecs[c].din));
        end
        check("free timeout", 64'(r_timeout), 64'(0));
        check("free writes", 64'(r_writes), 64'(12));

        // Backpressure in cycles 4-9.
        run_frame(1'b0, 12, 16, 1, 1'b0, 0);
        stalled = 0;
        for (int c = 4; c <= 9; c++) stalled += int'(rec_wr[c]);
        check("bp writes in 4-9", 64'(stalled), 64'(0));
        check("bp timeout", 64'(r_timeout), 64'(0));
        check("bp writes", 64'(r_writes), 64'(12));
        check("bp order", 64'(r_order_bad), 64'(0));
        check("bp addr", 64'(r_addr_bad), 64'(0));
        check("bp ahead<=2", 64'(r_max_out <= 2), 64'(1));
        check("bp done lat", 64'(r_done_c), 64'(r_last_wr + 1));
        check("bp done count", 64'(r_done_cnt), 64'(1));

        // Random 50% backpressure on the 16x8 frame.
        run_frame(1'b1, 128, 32, 2, 1'b0, 0);
        check("rnd timeout", 64'(r_timeout), 64'(0));
        check("rnd writes", 64'(r_writes), 64'(128));
        check("rnd order", 64'(r_order_bad), 64'(0));
        check("rnd addr", 64'(r_addr_bad), 64'(0));
        check("rnd write while full", 64'(r_stall_wr), 64'(0));
        check("rnd ahead<=2", 64'(r_max_out <= 2), 64'(1));
        check("rnd done lat", 64'(r_done_c), 64'(r_last_wr + 1));
        check("rnd done count", 64'(r_done_cnt), 64'(1));

        // Free-running 16x8 frame: last write at total+2, done at total+3.
        run_frame(1'b1, 128, 32, 0, 1'b0, 0);
        check("big last write", 64'(r_last_wr), 64'(130));
        check("big done", 64'(r_done_c), 64'(131));
        check("big order", 64'(r_order_bad), 64'(0));

        // Reset after the 5th write abandons the frame.
        run_frame(1'b0, 12, 16, 0, 1'b0, 5);
        check("mid writes before reset", 64'(r_writes), 64'(5));
        #1;
        reset = 1'b0;
        #1;
        check("mid rst strobes", 64'({rd_a, wr_a, done_a, busy_a}), 64'(0));
        check("mid rst addr", 64'(addr_a), 64'(16));
        check("mid rst din", 64'(din_a), 64'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            check($sformatf("mid held c%0d done/busy", c), 64'({done_a, busy_a}), 64'(0));
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            check($sformatf("mid post c%0d done/busy", c), 64'({done_a, busy_a}), 64'(0));
        end
        run_frame(1'b0, 12, 16, 0, 1'b0, 0);
        check("mid refr timeout", 64'(r_timeout), 64'(0));
        check("mid refr writes", 64'(r_writes), 64'(12));
        check("mid refr order", 64'(r_order_bad), 64'(0));
        check("mid refr addr", 64'(r_addr_bad), 64'(0));
        check("mid refr done", 64'(r_done_c), 64'(15));

        // start held through the frame.
        run_frame(1'b0, 12, 16, 0, 1'b1, 0);
        check("hold timeout", 64'(r_timeout), 64'(0));
        check("hold done", 64'(r_done_c), 64'(15));
        check("hold writes", 64'(r_writes), 64'(12));
        check("hold done count", 64'(r_done_cnt), 64'(1));
        check("hold next read", 64'(r_next_rd), 64'(r_done_c + 2));
        check("hold next addr", 64'(r_next_addr), 64'(16));
        got_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            #1;
            if (done_a) begin
                got_done = 1'b1;
                break;
            end
        end
        check("hold second frame done", 64'(got_done), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rgb_frame_reader.md
Name: rgb_frame_reader

Overview:
- Streams one RGB frame from a synchronous pixel memory into the write side of the RGB input FIFO of the Sobel pipeline.
- Acts as the writer for that FIFO: reads pixels in row-major order, honours `fifo_full` backpressure and absorbs the memory's 1-cycle read latency in a 2-entry holding buffer.
- Signals frame completion to the top-level controller.

Parameters:
- IMG_WIDTH, 720, pixels per row
- IMG_HEIGHT, 540, rows per frame
- RGB_DWIDTH, 24, pixel width in bits (matches RGB FIFO data width)
- ADDR_WIDTH, 19, memory address width; must satisfy BASE_ADDR + IMG_WIDTH*IMG_HEIGHT <= 2^ADDR_WIDTH
- BASE_ADDR, 0, memory address of pixel (row 0, col 0)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin frame transfer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel is written to the FIFO
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  read address, valid with mem_rd_en
- mem_dout  in  RGB_DWIDTH  read data, valid exactly 1 cycle after mem_rd_en
- fifo_wr_en  out  1  RGB FIFO write strobe
- fifo_din  out  RGB_DWIDTH  RGB FIFO write data
- fifo_full  in  1  RGB FIFO full

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0; done=0; mem_rd_en=0; mem_addr=BASE_ADDR; fifo_wr_en=0; fifo_din=0; address counter, in-flight flag and buffer occupancy all cleared. Any outstanding read data is discarded, and a partially sent frame is abandoned with no done pulse.
- States:
  - IDLE: start=1 -> READ; counter=0.
  - READ: issue reads; after the final issue -> DRAIN.
  - DRAIN: no reads; when buffer empty and nothing in flight -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- busy=1 in READ and DRAIN only. start is ignored outside IDLE.
- Counters:
  - `total` = IMG_WIDTH*IMG_HEIGHT.
  - mem_addr = BASE_ADDR + idx, where idx runs 0..total-1 in row-major order.
  - idx increments on each issued read; no wrap within a frame.
- Holding buffer:
  - 2 entries, FIFO order.
  - mem_dout is captured at the end of the cycle following mem_rd_en. Capture is unconditional; space is guaranteed by credits.
- Read issue, READ state:
  - mem_rd_en = (idx < total) && (occ + inflight - pop < 2).
  - occ is buffer occupancy (0..2), inflight is a read issued last cycle (0/1), and pop = fifo_wr_en this cycle.
  - This sustains 1 pixel/cycle with no backpressure.
- FIFO write:
  - fifo_wr_en = (occ > 0) && !fifo_full, combinational.
  - fifo_din = buffer head, also combinational.
  - A pop and a capture in the same cycle keep occ unchanged.
- fifo_full:
  - Stalls writes.
  - The buffer fills to 2, then reads stop.
  - No pixel is dropped, duplicated or reordered.
  - Release resumes the next cycle.
- Latency:
  - start sampled at end of cycle 0.
  - First mem_rd_en in cycle 1; first fifo_wr_en in cycle 3.
  - With no backpressure, the last write is in cycle total+2 and done is in cycle total+3.
- A start pulse arriving in the same cycle as done is ignored; a new start is accepted from IDLE onward.

Test Plan:
- Reset values: hold reset=0 with toggling start/fifo_full -> all outputs 0, mem_addr=BASE_ADDR; release, no start -> stays IDLE, no strobes.
- Free-running frame (IMG_WIDTH=4, IMG_HEIGHT=3, BASE_ADDR=16, memory word = addr*3), start in cycle 0:
  - mem_rd_en in cycles 1-12, addresses 16..27.
  - fifo_wr_en in cycles 3-14, data 48..81 in order.
  - done only in cycle 15; busy in cycles 1-14.
- Backpressure: same frame, fifo_full=1 in cycles 4-9:
  - No write in cycles 4-9; at most 2 reads issued beyond the last write.
  - All 12 pixels still written in order.
  - done 1 cycle after the 12th write.
- Random fifo_full (50%) on a 16x8 frame: scoreboard confirms exactly 128 writes, strictly ascending source order, and occ never exceeds 2.
- Reset mid-frame: assert reset after the 5th write -> outputs clear immediately, no done pulse; a new start sends the full frame from address BASE_ADDR.
- start held high through an entire frame -> frame sent once; second frame begins from IDLE only after done, with the first read 2 cycles after done.
